// File: rtl/ripemd160_pkg.sv
// RIPEMD-160 left-line constants and sequencer state type.
package ripemd160_pkg;

  localparam int unsigned RMD_ROUNDS = 80;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } rmd_state_t;

  localparam logic [3:0] RMD_LEFT_R [0:RMD_ROUNDS-1] = '{
    4'd0,  4'd1,  4'd2,  4'd3,  4'd4,  4'd5,  4'd6,  4'd7,
    4'd8,  4'd9,  4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15,
    4'd7,  4'd4,  4'd13, 4'd1,  4'd10, 4'd6,  4'd15, 4'd3,
    4'd12, 4'd0,  4'd9,  4'd5,  4'd2,  4'd14, 4'd11, 4'd8,
    4'd3,  4'd10, 4'd14, 4'd4,  4'd9,  4'd15, 4'd8,  4'd1,
    4'd2,  4'd7,  4'd0,  4'd6,  4'd13, 4'd11, 4'd5,  4'd12,
    4'd1,  4'd9,  4'd11, 4'd10, 4'd0,  4'd8,  4'd12, 4'd4,
    4'd13, 4'd3,  4'd7,  4'd15, 4'd14, 4'd5,  4'd6,  4'd2,
    4'd4,  4'd0,  4'd5,  4'd9,  4'd7,  4'd12, 4'd2,  4'd10,
    4'd14, 4'd1,  4'd3,  4'd8,  4'd11, 4'd6,  4'd15, 4'd13
  };

  localparam logic [7:0] RMD_LEFT_S [0:RMD_ROUNDS-1] = '{
    8'd11, 8'd14, 8'd15, 8'd12, 8'd5,  8'd8,  8'd7,  8'd9,
    8'd11, 8'd13, 8'd14, 8'd15, 8'd6,  8'd7,  8'd9,  8'd8,
    8'd7,  8'd6,  8'd8,  8'd13, 8'd11, 8'd9,  8'd7,  8'd15,
    8'd7,  8'd12, 8'd15, 8'd9,  8'd11, 8'd7,  8'd13, 8'd12,
    8'd11, 8'd13, 8'd6,  8'd7,  8'd14, 8'd9,  8'd13, 8'd15,
    8'd14, 8'd8,  8'd13, 8'd6,  8'd5,  8'd12, 8'd7,  8'd5,
    8'd11, 8'd12, 8'd14, 8'd15, 8'd14, 8'd15, 8'd9,  8'd8,
    8'd9,  8'd14, 8'd5,  8'd6,  8'd8,  8'd6,  8'd5,  8'd12,
    8'd9,  8'd15, 8'd5,  8'd11, 8'd6,  8'd8,  8'd13, 8'd12,
    8'd5,  8'd12, 8'd13, 8'd14, 8'd11, 8'd8,  8'd5,  8'd6
  };

  localparam logic [31:0] RMD_LEFT_K [0:4] = '{
    32'h00000000, 32'h5A827999, 32'h6ED9EBA1, 32'h8F1BBCDC, 32'hA953FD4E
  };

endpackage

// File: rtl/ripemd160_left_const_rom.sv
// Round index to (word select, rotate, constant, function select).
module ripemd160_left_const_rom
  import ripemd160_pkg::*;
(
  input  logic [6:0]  j,
  output logic [3:0]  r,
  output logic [7:0]  s,
  output logic [31:0] k,
  output logic [2:0]  t
);

  always_comb begin
    t = j[6:4];
    r = RMD_LEFT_R[j];
    s = RMD_LEFT_S[j];
    k = RMD_LEFT_K[j[6:4]];
  end

endmodule

// File: rtl/ripemd160_left_round_seq.sv
// RIPEMD-160 left-line round sequencer: one round per clock via an external round stage.
module ripemd160_left_round_seq
  import ripemd160_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] blk,
  input  logic [159:0] chain_in,
  output logic [159:0] rnd_state,
  output logic [31:0]  rnd_m,
  output logic [7:0]   rnd_s,
  output logic [31:0]  rnd_k,
  output logic [2:0]   rnd_t,
  input  logic [159:0] rnd_result,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [159:0] left_final
);

  rmd_state_t   state;
  logic [6:0]   j;
  logic [31:0]  msg [0:15];
  logic [159:0] work;

  logic [3:0]   rom_r;
  logic [7:0]   rom_s;
  logic [31:0]  rom_k;
  logic [2:0]   rom_t;

  ripemd160_left_const_rom u_rom (
    .j (j),
    .r (rom_r),
    .s (rom_s),
    .k (rom_k),
    .t (rom_t)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      j         <= '0;
      work      <= '0;
      out_valid <= 1'b0;
      for (int unsigned i = 0; i < 16; i++) msg[i] <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            for (int unsigned i = 0; i < 16; i++) msg[i] <= blk[32*i +: 32];
            work  <= chain_in;
            j     <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          work <= rnd_result;
          if (j == 7'(RMD_ROUNDS - 1)) begin
            j         <= '0;
            state     <= DONE;
            out_valid <= 1'b1;
          end else begin
            j <= j + 7'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    rnd_state = work;
    rnd_m     = '0;
    rnd_s     = '0;
    rnd_k     = '0;
    rnd_t     = '0;
    if (state == RUN) begin
      rnd_m = msg[rom_r];
      rnd_s = rom_s;
      rnd_k = rom_k;
      rnd_t = rom_t;
    end
  end

  assign in_ready   = (state == IDLE);
  assign left_final = work;

endmodule
